// File: rtl/latch_exerciser.sv
// Stimulus-and-check engine for a level-sensitive D latch under test: plays a fixed
// 12-step D/C sequence and compares Q/Qbar against a transparent-latch reference.
module latch_exerciser #(
    parameter int UNIT_CYCLES = 4,
    parameter int ERR_W       = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             LD,
    output logic             LC,
    input  logic             DQ,
    input  logic             DQBAR,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_STEP
);

    // The longest step is 10 units, so the counter only has to reach 10*UNIT_CYCLES-1.
    localparam int CNT_W = $clog2(10 * UNIT_CYCLES);
    localparam logic [3:0] LAST_STEP = 4'd11;
    localparam logic [3:0] NO_FAIL   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [3:0]       step;
    logic [CNT_W-1:0] cnt;
    logic             exp_q;
    logic             valid_q;

    function automatic logic step_lc(input logic [3:0] s);
        case (s)
            4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: step_lc = 1'b1;
            default:                                  step_lc = 1'b0;
        endcase
    endfunction

    function automatic logic step_ld(input logic [3:0] s);
        case (s)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd10: step_ld = 1'b1;
            default:                             step_ld = 1'b0;
        endcase
    endfunction

    function automatic int step_units(input logic [3:0] s);
        case (s)
            4'd0:                            step_units = 10;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9:    step_units = 1;
            default:                         step_units = 5;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] step_last(input logic [3:0] s);
        step_last = CNT_W'(step_units(s) * UNIT_CYCLES - 1);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    logic at_last;
    logic exp_nx;
    logic valid_nx;
    logic mism;
    logic start_run;

    // Reference latch update and Q/Qbar comparison for the sample cycle of a step.
    always_comb begin
        at_last   = (cnt == step_last(step));
        exp_nx    = LC ? LD : exp_q;
        valid_nx  = valid_q | LC;
        mism      = valid_nx && ((DQ != exp_nx) || (DQBAR != ~exp_nx));
        start_run = START && (state != S_RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            LD        <= 1'b0;
            LC        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_STEP <= NO_FAIL;
            step      <= 4'd0;
            cnt       <= '0;
            valid_q   <= 1'b0;
            exp_q     <= 1'b0;
        end else if (start_run) begin
            state     <= S_RUN;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_STEP <= NO_FAIL;
            valid_q   <= 1'b0;
            step      <= 4'd0;
            cnt       <= '0;
            LC        <= step_lc(4'd0);
            LD        <= step_ld(4'd0);
        end else if (state == S_RUN) begin
            if (at_last) begin
                exp_q   <= exp_nx;
                valid_q <= valid_nx;
                if (mism) begin
                    ERR_CNT <= sat_inc(ERR_CNT);
                    if (FAIL_STEP == NO_FAIL) FAIL_STEP <= step;
                end
                if (step == LAST_STEP) begin
                    state <= S_DONE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    LC    <= 1'b0;
                end else begin
                    step <= step + 4'd1;
                    cnt  <= '0;
                    LC   <= step_lc(step + 4'd1);
                    LD   <= step_ld(step + 4'd1);
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign PASS = DONE && (ERR_CNT == '0);

endmodule
